alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have ports: clk_in  input  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n_in  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: reqN_valid_in  input  1  (N=0,1) requester N has an operation.
REQ-004 SHALL have ports: reqN_ready_out  output  1  operation of requester N accepted this cycle.
REQ-005 SHALL have ports: reqN_unit_sel_in  input  3  ALU unit select for requester N.
REQ-006 SHALL have ports: reqN_op_sel_in  input  1  ALU op select (sub/nand/right-shift) for requester N.
REQ-007 SHALL have ports: reqN_acc_in, reqN_src_in  input  8 each  operands for requester N.
REQ-008 SHALL have ports: rspN_valid_out  output  1  result for requester N available.
REQ-009 SHALL have ports: rspN_ready_in  input  1  requester N consumes result.
REQ-010 SHALL have ports: rspN_res_out  output  8  result for requester N.
REQ-011 SHALL have ports: alu_unit_sel_out 3, alu_op_sel_out 1, alu_acc_out 8, alu_src_out 8  outputs driving the shared combinational ALU.
REQ-012 SHALL have ports: alu_res_in  input  8  combinational ALU result.
REQ-013 Clock/reset SHALL be exactly: one clock; reset asynchronous and active-low.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-015 IDLE: if any reqN_valid_in high, SHALL grant exactly one requester and assert its reqN_ready_out combinationally in the same cycle; other ready stays 0.
REQ-016 Arbitration SHALL be round-robin: on simultaneous valid, grant the requester not granted last; single valid always granted.
REQ-017 last_grant pointer SHALL update only when a transaction is accepted.
REQ-018 On handshake (valid & ready) SHALL register unit_sel, op_sel, acc, src and owner id; IDLE -> EXEC.
REQ-019 reqN_ready_out SHALL be 0 in EXEC and RESP.
REQ-020 alu_*_out SHALL be driven only from the registered operands (no combinational path from req inputs).
REQ-021 EXEC: SHALL capture alu_res_in into the 8-bit result register; EXEC -> RESP unconditionally (one cycle).
REQ-022 RESP: rspOWNER_valid_out SHALL be 1, other rsp valid 0; rspN_res_out SHALL present the result register for both N (qualified by valid).
REQ-023 RESP: result and valid SHALL hold stable until rspOWNER_ready_in high; on that edge RESP -> IDLE.
REQ-024 Latency: accept edge at cycle T -> rsp valid from cycle T+2; max throughput one op per 3 cycles with ready_in held high.
REQ-025 A new request asserted during EXEC/RESP SHALL wait; it is eligible in the IDLE cycle after RESP exits.
REQ-026 A requester dropping valid in IDLE before grant SHALL cause no state change.
REQ-027 rspN_ready_in when not owner or not in RESP SHALL be ignored.
REQ-028 Registered operands SHALL hold their values in IDLE and RESP (alu_*_out stable between transactions).

Reset
REQ-029 Reset assertion SHALL immediately force state IDLE, all ready/valid outputs 0, result and operand registers 0, last_grant = 1 (requester 0 wins first tie).
REQ-030 Reset mid-transaction SHALL drop the in-flight op with no response ever issued.
REQ-031 Outputs after reset: alu_unit_sel_out=0, alu_op_sel_out=0, alu_acc_out=0, alu_src_out=0, rspN_res_out=0.

Verification
REQ-032 Both valid after reset, req0 ADD acc=0x05 src=0x03, req1 SUB acc=0x10 src=0x01 -> req0 granted, rsp0 0x08 at T+2; next grant req1, rsp1 0x0F.
REQ-033 req1 alone, unit 3'b010 op_sel=1 acc=0x80 src=0x03, rsp1_ready_in low 4 cycles -> rsp1_valid_out and 0x10 held 4+ cycles, IDLE only after ready.
REQ-034 Both valid continuously, rsp ready high -> grants alternate 0,1,0,1; one accept every 3 cycles; never two readys in one cycle.
REQ-035 Reset pulsed during EXEC of req0 -> no rsp0_valid_out afterwards; all outputs 0; next tie grants req0.
REQ-036 Req0 operands changed after handshake during EXEC -> result reflects captured operands (MUL 0x0F*0x11 -> 0xFF).
REQ-037 rsp0_ready_in high while req1 owns RESP -> no state change, rsp1 still valid.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each transaction is accepted in IDLE, executed in EXEC, and returned in RESP.
module alu_arbiter (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       req0_valid_in,
  output logic       req0_ready_out,
  input  logic [2:0] req0_unit_sel_in,
  input  logic       req0_op_sel_in,
  input  logic [7:0] req0_acc_in,
  input  logic [7:0] req0_src_in,
  output logic       rsp0_valid_out,
  input  logic       rsp0_ready_in,
  output logic [7:0] rsp0_res_out,
  input  logic       req1_valid_in,
  output logic       req1_ready_out,
  input  logic [2:0] req1_unit_sel_in,
  input  logic       req1_op_sel_in,
  input  logic [7:0] req1_acc_in,
  input  logic [7:0] req1_src_in,
  output logic       rsp1_valid_out,
  input  logic       rsp1_ready_in,
  output logic [7:0] rsp1_res_out,
  output logic [2:0] alu_unit_sel_out,
  output logic       alu_op_sel_out,
  output logic [7:0] alu_acc_out,
  output logic [7:0] alu_src_out,
  input  logic [7:0] alu_res_in
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       owner_q, owner_d;
  logic [2:0] unit_q, unit_d;
  logic       op_q, op_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] src_q, src_d;
  logic [7:0] res_q, res_d;
  logic       rsp0_valid_q, rsp0_valid_d;
  logic       rsp1_valid_q, rsp1_valid_d;
  logic       grant0_s, grant1_s;
  logic       owner_ready_s;

  // Round-robin grant; ready is gated by reset so it drops the moment reset asserts
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_q == IDLE) && rst_n_in) begin
      if (req0_valid_in && (!req1_valid_in || last_grant_q)) begin
        grant0_s = 1'b1;
      end else if (req1_valid_in) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready_out = grant0_s;
  assign req1_ready_out = grant1_s;
  assign owner_ready_s  = owner_q ? rsp1_ready_in : rsp0_ready_in;

  // Next-state and datapath register updates for the three-phase transaction
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    unit_d       = unit_q;
    op_d         = op_q;
    acc_d        = acc_q;
    src_d        = src_q;
    res_d        = res_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    case (state_q)
      IDLE: begin
        if (grant0_s) begin
          unit_d       = req0_unit_sel_in;
          op_d         = req0_op_sel_in;
          acc_d        = req0_acc_in;
          src_d        = req0_src_in;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = EXEC;
        end else if (grant1_s) begin
          unit_d       = req1_unit_sel_in;
          op_d         = req1_op_sel_in;
          acc_d        = req1_acc_in;
          src_d        = req1_src_in;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        res_d        = alu_res_in;
        rsp0_valid_d = ~owner_q;
        rsp1_valid_d = owner_q;
        state_d      = RESP;
      end
      RESP: begin
        if (owner_ready_s) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State, operand, result and response-valid registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      unit_q       <= 3'd0;
      op_q         <= 1'b0;
      acc_q        <= 8'd0;
      src_q        <= 8'd0;
      res_q        <= 8'd0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      unit_q       <= unit_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      src_q        <= src_d;
      res_q        <= res_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign rsp0_valid_out   = rsp0_valid_q;
  assign rsp1_valid_out   = rsp1_valid_q;
  assign rsp0_res_out     = res_q;
  assign rsp1_res_out     = res_q;
  assign alu_unit_sel_out = unit_q;
  assign alu_op_sel_out   = op_q;
  assign alu_acc_out      = acc_q;
  assign alu_src_out      = src_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_alu_arbiter;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b1;
  logic       req0_valid_in, req0_ready_out, req0_op_sel_in;
  logic [2:0] req0_unit_sel_in;
  logic [7:0] req0_acc_in, req0_src_in;
  logic       rsp0_valid_out, rsp0_ready_in;
  logic [7:0] rsp0_res_out;
  logic       req1_valid_in, req1_ready_out, req1_op_sel_in;
  logic [2:0] req1_unit_sel_in;
  logic [7:0] req1_acc_in, req1_src_in;
  logic       rsp1_valid_out, rsp1_ready_in;
  logic [7:0] rsp1_res_out;
  logic [2:0] alu_unit_sel_out;
  logic       alu_op_sel_out;
  logic [7:0] alu_acc_out, alu_src_out, alu_res_in;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  alu_arbiter dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req0_valid_in(req0_valid_in), .req0_ready_out(req0_ready_out),
    .req0_unit_sel_in(req0_unit_sel_in), .req0_op_sel_in(req0_op_sel_in),
    .req0_acc_in(req0_acc_in), .req0_src_in(req0_src_in),
    .rsp0_valid_out(rsp0_valid_out), .rsp0_ready_in(rsp0_ready_in), .rsp0_res_out(rsp0_res_out),
    .req1_valid_in(req1_valid_in), .req1_ready_out(req1_ready_out),
    .req1_unit_sel_in(req1_unit_sel_in), .req1_op_sel_in(req1_op_sel_in),
    .req1_acc_in(req1_acc_in), .req1_src_in(req1_src_in),
    .rsp1_valid_out(rsp1_valid_out), .rsp1_ready_in(rsp1_ready_in), .rsp1_res_out(rsp1_res_out),
    .alu_unit_sel_out(alu_unit_sel_out), .alu_op_sel_out(alu_op_sel_out),
    .alu_acc_out(alu_acc_out), .alu_src_out(alu_src_out), .alu_res_in(alu_res_in)
  );

  // Shared ALU behaviour: 0 add/sub, 1 and/nand, 2 shl/shr, 3 mul, else or/xor
  function automatic logic [7:0] alu_f(input logic [2:0] u, input logic o,
                                       input logic [7:0] a, input logic [7:0] s);
    logic [15:0] p;
    p = 16'(a) * 16'(s);
    case (u)
      3'd0:    return o ? (a - s) : (a + s);
      3'd1:    return o ? ~(a & s) : (a & s);
      3'd2:    return o ? (a >> s[2:0]) : (a << s[2:0]);
      3'd3:    return p[7:0];
      default: return o ? (a ^ s) : (a | s);
    endcase
  endfunction

  assign alu_res_in = alu_f(alu_unit_sel_out, alu_op_sel_out, alu_acc_out, alu_src_out);

  // Transaction model: busy flag, owner, cycles since accept, captured operands
  bit         m_busy;
  int         m_owner, m_age, m_last;
  logic [2:0] m_unit;
  logic       m_op;
  logic [7:0] m_acc, m_src, m_res;
  logic       e_g0, e_g1, s_rr0, s_rr1;
  logic [2:0] p_unit;
  logic       p_op;
  logic [7:0] p_acc, p_src;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_age = 0; m_last = 1;
    m_unit = 3'd0; m_op = 1'b0; m_acc = 8'd0; m_src = 8'd0; m_res = 8'd0;
  endtask

  task automatic set_req(input int n, input logic v, input logic [2:0] u, input logic o,
                         input logic [7:0] a, input logic [7:0] s);
    if (n == 0) begin
      req0_valid_in = v; req0_unit_sel_in = u; req0_op_sel_in = o; req0_acc_in = a; req0_src_in = s;
    end else begin
      req1_valid_in = v; req1_unit_sel_in = u; req1_op_sel_in = o; req1_acc_in = a; req1_src_in = s;
    end
  endtask

  task automatic compare();
    e_g0 = !m_busy && req0_valid_in && (!req1_valid_in || m_last == 1);
    e_g1 = !m_busy && req1_valid_in && !e_g0;
    check("ready0", 8'(req0_ready_out), 8'(e_g0));
    check("ready1", 8'(req1_ready_out), 8'(e_g1));
    check("rsp0_valid", 8'(rsp0_valid_out), 8'(m_busy && m_age >= 1 && m_owner == 0));
    check("rsp1_valid", 8'(rsp1_valid_out), 8'(m_busy && m_age >= 1 && m_owner == 1));
    check("rsp0_res", rsp0_res_out, m_res);
    check("rsp1_res", rsp1_res_out, m_res);
    check("alu_unit", 8'(alu_unit_sel_out), 8'(m_unit));
    check("alu_op", 8'(alu_op_sel_out), 8'(m_op));
    check("alu_acc", alu_acc_out, m_acc);
    check("alu_src", alu_src_out, m_src);
    p_unit = e_g1 ? req1_unit_sel_in : req0_unit_sel_in;
    p_op   = e_g1 ? req1_op_sel_in   : req0_op_sel_in;
    p_acc  = e_g1 ? req1_acc_in      : req0_acc_in;
    p_src  = e_g1 ? req1_src_in      : req0_src_in;
    s_rr0  = rsp0_ready_in;
    s_rr1  = rsp1_ready_in;
  endtask

  task automatic update();
    if (!m_busy) begin
      if (e_g0 || e_g1) begin
        m_busy = 1'b1; m_age = 0; m_owner = e_g1 ? 1 : 0; m_last = m_owner;
        m_unit = p_unit; m_op = p_op; m_acc = p_acc; m_src = p_src;
      end
    end else if (m_age == 0) begin
      m_age = 1;
      m_res = alu_f(m_unit, m_op, m_acc, m_src);
    end else if ((m_owner == 0 && s_rr0) || (m_owner == 1 && s_rr1)) begin
      m_busy = 1'b0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model after the rising edge
  task automatic tick();
    @(negedge clk_in);
    compare();
    @(posedge clk_in);
    #1;
    update();
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_ready0"}, 8'(req0_ready_out), 8'd0);
    check({tag, "_ready1"}, 8'(req1_ready_out), 8'd0);
    check({tag, "_rsp0v"}, 8'(rsp0_valid_out), 8'd0);
    check({tag, "_rsp1v"}, 8'(rsp1_valid_out), 8'd0);
    check({tag, "_res"}, rsp0_res_out | rsp1_res_out, 8'd0);
    check({tag, "_alu"}, alu_acc_out | alu_src_out | 8'(alu_unit_sel_out) | 8'(alu_op_sel_out), 8'd0);
  endtask

  // Asynchronous reset pulse, started just after a rising edge
  task automatic do_reset();
    #2;
    rst_n_in = 1'b0;
    req0_valid_in = 1'b1;
    req1_valid_in = 1'b1;
    #1;
    all_zero("rst");
    req0_valid_in = 1'b0;
    req1_valid_in = 1'b0;
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    set_req(0, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0);
    set_req(1, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0);
    rsp0_ready_in = 1'b0;
    rsp1_ready_in = 1'b0;
    model_reset();
    @(posedge clk_in);
    #1;
    do_reset();

    // Tie after reset goes to req0: 5+3, then req1: 0x10-1
    set_req(0, 1'b1, 3'd0, 1'b0, 8'h05, 8'h03);
    set_req(1, 1'b1, 3'd0, 1'b1, 8'h10, 8'h01);
    rsp0_ready_in = 1'b1;
    rsp1_ready_in = 1'b1;
    #1;
    check("tie_ready0", 8'(req0_ready_out), 8'd1);
    check("tie_ready1", 8'(req1_ready_out), 8'd0);
    tick();
    req0_valid_in = 1'b0;
    tick();
    check("add_valid", 8'(rsp0_valid_out), 8'd1);
    check("add_res", rsp0_res_out, 8'h08);
    tick();
    tick();
    req1_valid_in = 1'b0;
    tick();
    check("sub_valid", 8'(rsp1_valid_out), 8'd1);
    check("sub_res", rsp1_res_out, 8'h0F);
    tick();

    // req1 alone, right shift, response held while rsp1_ready is low
    set_req(1, 1'b1, 3'b010, 1'b1, 8'h80, 8'h03);
    rsp1_ready_in = 1'b0;
    tick();
    req1_valid_in = 1'b0;
    tick();
    rsp0_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", 8'(rsp1_valid_out), 8'd1);
      check("hold_res", rsp1_res_out, 8'h10);
      check("hold_rsp0v", 8'(rsp0_valid_out), 8'd0);
      tick();
    end
    rsp1_ready_in = 1'b1;
    tick();
    check("hold_release", 8'(rsp1_valid_out), 8'd0);

    // Operands changed after handshake do not affect the result
    set_req(0, 1'b1, 3'd3, 1'b0, 8'h0F, 8'h11);
    tick();
    set_req(0, 1'b0, 3'd0, 1'b1, 8'hAA, 8'h55);
    tick();
    check("mul_res", rsp0_res_out, 8'hFF);
    tick();

    // Reset in EXEC drops the operation; next tie still goes to req0
    set_req(0, 1'b1, 3'd0, 1'b0, 8'h22, 8'h33);
    tick();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("drop_rsp0v", 8'(rsp0_valid_out), 8'd0);
      tick();
    end

    // Continuous contention: grants alternate 0,1,0,1 every third cycle
    set_req(0, 1'b1, 3'd1, 1'b1, 8'h3C, 8'h0F);
    set_req(1, 1'b1, 3'd4, 1'b0, 8'h81, 8'h18);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("alt_ready0", 8'(req0_ready_out), 8'((k % 2) == 0));
      check("alt_ready1", 8'(req1_ready_out), 8'((k % 2) == 1));
      tick();
      tick();
      tick();
    end

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        set_req(0, 1'($urandom_range(99) < 60), 3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        set_req(1, 1'($urandom_range(99) < 60), 3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        rsp0_ready_in = 1'($urandom);
        rsp1_ready_in = 1'($urandom);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
